// File: rtl/fix_pkg.sv
// Shared constants, FSM state enum and descriptor layout for the FIX tag extractor.
package fix_pkg;

    localparam logic [7:0] FIX_SOH     = 8'h01;
    localparam logic [7:0] FIX_EQ      = 8'h3D;
    localparam logic [7:0] FIX_MAX_LEN = 8'hFF;

    typedef enum logic [1:0] {
        S_TAG  = 2'd0,
        S_VAL  = 2'd1,
        S_PUSH = 2'd2,
        S_SKIP = 2'd3
    } fix_state_e;

    typedef struct packed {
        logic [7:0]  len;
        logic [23:0] tag;
    } fix_desc_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

endpackage

// File: rtl/fix_dec_accum.sv
// One decimal accumulation step: acc*10 + digit, with overflow taken from the
// full-width intermediate so a wrapped result can never look legal.
module fix_dec_accum #(
    parameter int TAG_WIDTH = 24
) (
    input  logic [TAG_WIDTH-1:0] acc,
    input  logic [3:0]           digit,
    output logic [TAG_WIDTH-1:0] acc_next,
    output logic                 ovf
);

    logic [TAG_WIDTH+3:0] prod;

    assign prod     = {4'b0, acc} * (TAG_WIDTH+4)'(10) + {{TAG_WIDTH{1'b0}}, digit};
    assign acc_next = prod[TAG_WIDTH-1:0];
    assign ovf      = |prod[TAG_WIDTH+3:TAG_WIDTH];

endmodule

// File: rtl/fix_tag_extractor.sv
// FIX byte stream -> {len, tag} descriptors pushed into the tag FIFO.
// Define FIX_ERR_CNT_EN to add the saturating err_cnt_o counter.
module fix_tag_extractor
    import fix_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    input  logic                  full_i,
    output logic                  wr_cs_o,
    output logic                  wr_en_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  err_o
`ifdef FIX_ERR_CNT_EN
    ,
    output logic [15:0]           err_cnt_o
`endif
);

    localparam int LEN_WIDTH = DATA_WIDTH - TAG_WIDTH;

    fix_state_e           state;
    logic [TAG_WIDTH-1:0] tag_acc;
    logic [LEN_WIDTH-1:0] len_acc;
    logic [3:0]           dig_cnt;
    logic [TAG_WIDTH-1:0] tag_next;
    logic                 tag_ovf;

    fix_dec_accum #(.TAG_WIDTH(TAG_WIDTH)) u_accum (
        .acc      (tag_acc),
        .digit    (byte_i[3:0]),
        .acc_next (tag_next),
        .ovf      (tag_ovf)
    );

    assign byte_ready_o = (state != S_PUSH);
    assign wr_cs_o      = (state == S_PUSH) && !full_i;
    assign wr_en_o      = wr_cs_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_TAG;
            tag_acc <= '0;
            len_acc <= '0;
            dig_cnt <= '0;
            data_o  <= '0;
            err_o   <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                S_TAG: if (byte_valid_i) begin
                    if (is_digit(byte_i)) begin
                        if (tag_ovf) begin
                            err_o <= 1'b1;
                            state <= S_SKIP;
                        end else begin
                            tag_acc <= tag_next;
                            if (dig_cnt != '1) dig_cnt <= dig_cnt + 4'd1;
                        end
                    end else if (byte_i == FIX_EQ) begin
                        if (dig_cnt == '0) begin
                            err_o <= 1'b1;
                            state <= S_SKIP;
                        end else begin
                            len_acc <= '0;
                            state   <= S_VAL;
                        end
                    end else if (byte_i == FIX_SOH) begin
                        // bare SOH with no digits is an empty field, not an error
                        if (dig_cnt != '0) begin
                            err_o <= 1'b1;
                            state <= S_SKIP;
                        end
                    end else begin
                        err_o <= 1'b1;
                        state <= S_SKIP;
                    end
                end
                S_VAL: if (byte_valid_i) begin
                    if (byte_i == FIX_SOH) begin
                        data_o <= {len_acc, tag_acc};
                        state  <= S_PUSH;
                    end else if (len_acc != '1) begin
                        len_acc <= len_acc + 1'b1;
                    end
                end
                S_PUSH: if (!full_i) begin
                    tag_acc <= '0;
                    dig_cnt <= '0;
                    state   <= S_TAG;
                end
                S_SKIP: if (byte_valid_i && byte_i == FIX_SOH) begin
                    tag_acc <= '0;
                    len_acc <= '0;
                    dig_cnt <= '0;
                    state   <= S_TAG;
                end
                default: state <= S_TAG;
            endcase
        end
    end

`ifdef FIX_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           err_cnt_o <= '0;
        else if (err_o && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 16'd1;
    end
`endif

endmodule
